// File: rtl/clock_divider.sv
// Free-running tick generator: divides sys_clk into a 1 Hz enable pulse,
// a 2 Hz enable pulse and a 50%-duty blink level, all registered.
module clock_divider #(
  parameter  int CLK_FREQ_HZ = 100_000_000,
  parameter  int TICK_HZ     = 1,
  localparam int DIV         = CLK_FREQ_HZ / TICK_HZ,
  localparam int CW          = $clog2(DIV)
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  output logic          clk_1hz_en,
  output logic          clk_2hz_en,
  output logic          blink,
  output logic [CW-1:0] tick_cnt
);

  localparam int HALF = DIV / 2;

  localparam logic [CW-1:0] CNT_LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_PRE_LAST  = CW'(DIV - 2);
  localparam logic [CW-1:0] CNT_PRE_HALF  = CW'(HALF - 2);
  localparam logic [CW-1:0] CNT_HALF      = CW'(HALF);

  // An odd or tiny divider cannot give a 50% blink and two distinct 2 Hz slots.
  if ((DIV < 4) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("clock_divider: DIV=%0d must be even and at least 4", DIV);
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          one_q, one_d;
  logic          two_q, two_d;
  logic          blink_q, blink_d;

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    // Pulses are decoded one count early so they are high while cnt_q sits
    // on the decoded slot (DIV/2-1 and DIV-1).
    one_d   = (cnt_q == CNT_PRE_LAST);
    two_d   = (cnt_q == CNT_PRE_LAST) || (cnt_q == CNT_PRE_HALF);
    blink_d = (cnt_d >= CNT_HALF);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      one_q   <= 1'b0;
      two_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      one_q   <= one_d;
      two_q   <= two_d;
      blink_q <= blink_d;
    end
  end

  assign tick_cnt   = cnt_q;
  assign clk_1hz_en = one_q;
  assign clk_2hz_en = two_q;
  assign blink      = blink_q;

endmodule

// File: tb/tb_clock_divider.sv
// Directed bench for clock_divider: three instances (DIV=10, DIV=100 via
// TICK_HZ=2, and defaults) checked every cycle against an edge-count model.
module tb_clock_divider;

  logic sys_clk;
  logic rst_n;

  logic       one_a, two_a, blink_a;
  logic [3:0] cnt_a;
  logic       one_b, two_b, blink_b;
  logic [6:0] cnt_b;
  logic        one_c, two_c, blink_c;
  logic [26:0] cnt_c;

  int checks;
  int failures;
  int edges;

  int pulses_a, pulses2_a, blinkhi_a, last_pulse_a, max_gap_a, min_gap_a;
  int pulses_b, first_pulse_b;
  int pulses_c;

  clock_divider #(.CLK_FREQ_HZ(10), .TICK_HZ(1)) u_div10 (
    .sys_clk(sys_clk), .rst_n(rst_n), .clk_1hz_en(one_a),
    .clk_2hz_en(two_a), .blink(blink_a), .tick_cnt(cnt_a)
  );

  clock_divider #(.CLK_FREQ_HZ(200), .TICK_HZ(2)) u_div100 (
    .sys_clk(sys_clk), .rst_n(rst_n), .clk_1hz_en(one_b),
    .clk_2hz_en(two_b), .blink(blink_b), .tick_cnt(cnt_b)
  );

  clock_divider u_default (
    .sys_clk(sys_clk), .rst_n(rst_n), .clk_1hz_en(one_c),
    .clk_2hz_en(two_c), .blink(blink_c), .tick_cnt(cnt_c)
  );

  // clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edges);
    end
  endtask

  // Expected outputs after `edges` active edges since reset release.
  function automatic logic exp_one(input int e, input int div);
    return (e > 0) && ((e % div) == div - 1);
  endfunction
  function automatic logic exp_two(input int e, input int div);
    return (e > 0) && (((e % div) == div - 1) || ((e % div) == div / 2 - 1));
  endfunction
  function automatic logic exp_blink(input int e, input int div);
    return (e % div) >= div / 2;
  endfunction

  task automatic clear_stats();
    pulses_a = 0; pulses2_a = 0; blinkhi_a = 0;
    last_pulse_a = -1; max_gap_a = 0; min_gap_a = 1 << 30;
    pulses_b = 0; first_pulse_b = -1; pulses_c = 0;
  endtask

  // Drive rst_n for one active edge, then check every instance.
  task automatic tick(input logic r);
    rst_n = r;
    @(posedge sys_clk);
    #1;
    if (!r) edges = 0;
    else edges++;
    check("cnt10",   32'(cnt_a),   32'(edges % 10));
    check("one10",   32'(one_a),   32'(exp_one(edges, 10)));
    check("two10",   32'(two_a),   32'(exp_two(edges, 10)));
    check("blink10", 32'(blink_a), 32'(exp_blink(edges, 10)));
    check("cnt100",  32'(cnt_b),   32'(edges % 100));
    check("one100",  32'(one_b),   32'(exp_one(edges, 100)));
    check("cntdef",  32'(cnt_c),   32'(edges));
    check("onedef",  32'(one_c),   32'b0);
    check("twodef",  32'(two_c),   32'b0);
    check("blinkdef",32'(blink_c), 32'b0);
    if (one_a) begin
      pulses_a++;
      if (last_pulse_a >= 0) begin
        if (edges - last_pulse_a > max_gap_a) max_gap_a = edges - last_pulse_a;
        if (edges - last_pulse_a < min_gap_a) min_gap_a = edges - last_pulse_a;
      end
      last_pulse_a = edges;
    end
    if (two_a) pulses2_a++;
    if (blink_a) blinkhi_a++;
    if (one_b) begin
      pulses_b++;
      if (first_pulse_b < 0) first_pulse_b = edges;
    end
    if (one_c) pulses_c++;
  endtask

  initial begin
    int waited;
    checks = 0; failures = 0; edges = 0;
    rst_n = 1'b0;
    clear_stats();

    // Reset hold: everything zero for 10 edges.
    for (int i = 0; i < 10; i++) tick(1'b0);

    // Period, 2 Hz and blink on DIV=10 over 30 edges, then 5 more.
    clear_stats();
    for (int i = 0; i < 30; i++) tick(1'b1);
    check("p2_count_30", 32'(pulses2_a), 32'd6);
    check("blink_hi_30", 32'(blinkhi_a), 32'd15);
    for (int i = 0; i < 5; i++) tick(1'b1);
    check("p1_count_35", 32'(pulses_a), 32'd3);
    check("p1_last_edge", 32'(last_pulse_a), 32'd29);

    // Mid-period reset at tick_cnt==6.
    for (int i = 0; i < 10; i++) tick(1'b0);
    clear_stats();
    for (int i = 0; i < 6; i++) tick(1'b1);
    check("pre_rst_cnt", 32'(cnt_a), 32'd6);
    tick(1'b0);
    check("mid_rst_cnt", 32'(cnt_a), 32'd0);
    check("mid_rst_no_pulse", 32'(pulses_a), 32'd0);
    waited = 0;
    while (!one_a && waited < 20) begin
      tick(1'b1);
      waited++;
    end
    check("post_rst_latency", 32'(waited), 32'd9);

    // Long run: no drift on DIV=10, scaled single-pulse window on DIV=100.
    for (int i = 0; i < 3; i++) tick(1'b0);
    clear_stats();
    for (int i = 0; i < 1000; i++) tick(1'b1);
    check("long_pulses10", 32'(pulses_a), 32'd100);
    check("long_max_gap", 32'(max_gap_a), 32'd10);
    check("long_min_gap", 32'(min_gap_a), 32'd10);
    check("long_pulses100", 32'(pulses_b), 32'd10);
    check("first_pulse100", 32'(first_pulse_b), 32'd99);
    check("default_pulses", 32'(pulses_c), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
